vip_bch_syndrome: RTL and testbench

VIP_BCH_SYNDROME -- requirements
Module: vip_bch_syndrome

---
 rtl/vip_bch_constants_pkg.sv | 15 +
 rtl/vip_bch_types_pkg.sv | 17 +
 rtl/vip_bch_gf_mul_alpha.sv | 24 ++
 rtl/vip_bch_syndrome.sv | 118 +++++++++++
 tb/tb_vip_bch_syndrome.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_bch_constants_pkg.sv
// Field-size limits for the BCH syndrome blocks and the parameter legality rule
// shared by every block that elaborates a BCH code.
package vip_bch_constants_pkg;

    localparam int unsigned MIN_M_C = 3;
    localparam int unsigned MAX_M_C = 16;

    // A code is legal when the field is in range, t >= 1, and m*t parity bits fit in n = 2^m-1.
    function automatic bit bch_params_ok(input int unsigned m, input int unsigned t);
        int unsigned n;
        n = (32'd1 << m) - 32'd1;
        return (m >= MIN_M_C) && (m <= MAX_M_C) && (t >= 1) && ((m * t) < n);
    endfunction

endpackage

// File: rtl/vip_bch_types_pkg.sv
// Shared types for the BCH syndrome path: FSM state and syndrome storage.
package vip_bch_types_pkg;

    import vip_bch_constants_pkg::*;

    localparam int unsigned MAX_SYN_C = 32;

    typedef enum logic [1:0] {
        SYN_IDLE_E,
        SYN_ACC_E,
        SYN_OUT_E
    } syn_state_e;

    typedef logic [MAX_M_C-1:0] gf_elem_t;
    typedef gf_elem_t syn_array_t [MAX_SYN_C];

endpackage

// File: rtl/vip_bch_gf_mul_alpha.sv
// Combinational multiply of a GF(2^M_P) element by the constant alpha^POWER_P.
module vip_bch_gf_mul_alpha #(
    parameter int unsigned   M_P         = 4,
    parameter logic [M_P:0]  PRIM_POLY_P = 5'b10011,
    parameter int unsigned   POWER_P     = 1
) (
    input  logic [M_P-1:0] elem,
    output logic [M_P-1:0] prod
);

    localparam logic [M_P-1:0] POLY_LOW = PRIM_POLY_P[M_P-1:0];

    logic [M_P-1:0] acc;

    // Repeated multiply-by-x with reduction; unrolls to a fixed XOR network.
    always_comb begin
        acc = elem;
        for (int unsigned i = 0; i < POWER_P; i++) begin
            acc = {acc[M_P-2:0], 1'b0} ^ (acc[M_P-1] ? POLY_LOW : '0);
        end
        prod = acc;
    end

endmodule

// File: rtl/vip_bch_syndrome.sv
// Serial BCH syndrome generator: Horner-evaluates the received word at alpha^1..alpha^2T,
// one bit per cycle, and hands the result out over a valid/ready port.
module vip_bch_syndrome
    import vip_bch_constants_pkg::*;
    import vip_bch_types_pkg::*;
#(
    parameter int unsigned  M_P         = 4,
    parameter int unsigned  T_P         = 2,
    parameter logic [M_P:0] PRIM_POLY_P = 5'b10011
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   rx_bit,
    input  logic                   rx_last,
    output logic                   syn_valid,
    input  logic                   syn_ready,
    output logic [2*T_P*M_P-1:0]   syn_data,
    output logic                   syn_error,
    output logic                   syn_len_err
);

    localparam int unsigned N_C   = (32'd1 << M_P) - 32'd1;
    localparam int unsigned SYN_N = 2 * T_P;
    localparam int unsigned SYN_W = SYN_N * M_P;
    localparam int unsigned CNT_W = M_P;

    if (!bch_params_ok(M_P, T_P)) begin : g_param_check
        $error("vip_bch_syndrome: illegal M_P/T_P combination");
    end

    syn_state_e      state_q;
    logic [M_P-1:0]  syn_q   [SYN_N];
    logic [M_P-1:0]  syn_mul [SYN_N];
    logic [CNT_W-1:0] cnt_q;
    logic [SYN_W-1:0] syn_next;
    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] cnt_next;
    logic             rx_xfer;
    logic             len_bad;

    for (genvar j = 0; j < SYN_N; j++) begin : g_mul
        vip_bch_gf_mul_alpha #(
            .M_P        (M_P),
            .PRIM_POLY_P(PRIM_POLY_P),
            .POWER_P    (j + 1)
        ) u_mul (
            .elem(syn_q[j]),
            .prod(syn_mul[j])
        );
    end

    // Horner step; the first bit of a word starts from zero instead of the stale syndromes.
    always_comb begin
        syn_next = '0;
        for (int unsigned j = 0; j < SYN_N; j++) begin
            syn_next[j*M_P +: M_P] = ((state_q == SYN_IDLE_E) ? '0 : syn_mul[j])
                                   ^ {{(M_P-1){1'b0}}, rx_bit};
        end
    end

    // Index of the bit being transferred; saturates at N_C so overlong words stay flagged.
    always_comb begin
        rx_xfer  = rx_valid && rx_ready;
        bit_idx  = (state_q == SYN_IDLE_E) ? '0 : cnt_q;
        len_bad  = (bit_idx != CNT_W'(N_C - 1));
        cnt_next = (bit_idx == CNT_W'(N_C)) ? bit_idx : bit_idx + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYN_IDLE_E;
            cnt_q       <= '0;
            rx_ready    <= 1'b0;
            syn_valid   <= 1'b0;
            syn_data    <= '0;
            syn_error   <= 1'b0;
            syn_len_err <= 1'b0;
            for (int unsigned j = 0; j < SYN_N; j++) begin
                syn_q[j] <= '0;
            end
        end else begin
            case (state_q)
                SYN_IDLE_E, SYN_ACC_E: begin
                    rx_ready <= 1'b1;
                    if (rx_xfer) begin
                        for (int unsigned j = 0; j < SYN_N; j++) begin
                            syn_q[j] <= syn_next[j*M_P +: M_P];
                        end
                        cnt_q <= cnt_next;
                        if (rx_last) begin
                            state_q     <= SYN_OUT_E;
                            rx_ready    <= 1'b0;
                            syn_valid   <= 1'b1;
                            syn_data    <= syn_next;
                            syn_error   <= |syn_next;
                            syn_len_err <= len_bad;
                        end else begin
                            state_q <= SYN_ACC_E;
                        end
                    end
                end
                SYN_OUT_E: begin
                    if (syn_ready) begin
                        state_q   <= SYN_IDLE_E;
                        syn_valid <= 1'b0;
                        rx_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SYN_IDLE_E;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vip_bch_syndrome.sv
// Directed and randomized checks of vip_bch_syndrome against a polynomial-evaluation model.
module tb_vip_bch_syndrome;

    localparam int unsigned M  = 4;
    localparam int unsigned T  = 2;
    localparam int unsigned N  = 15;
    localparam int unsigned SW = 2 * T * M;
    localparam int unsigned GEN_POLY = 32'h1D1;   // x^8+x^7+x^6+x^4+1

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          rx_bit = 1'b0;
    logic          rx_last = 1'b0;
    logic          syn_valid;
    logic          syn_ready = 1'b0;
    logic [SW-1:0] syn_data;
    logic          syn_error;
    logic          syn_len_err;

    int errors = 0;
    int checks = 0;
    int alog [N];
    bit cw [$];

    vip_bch_syndrome dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_bit     (rx_bit),
        .rx_last    (rx_last),
        .syn_valid  (syn_valid),
        .syn_ready  (syn_ready),
        .syn_data   (syn_data),
        .syn_error  (syn_error),
        .syn_len_err(syn_len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // S_j = r(alpha^j), summing alpha^(j*deg) over every set coefficient of r(x).
    function automatic logic [SW-1:0] ref_syn();
        logic [SW-1:0] res;
        int            len;
        int            s;
        res = '0;
        len = cw.size();
        for (int j = 1; j <= 2 * T; j++) begin
            s = 0;
            for (int k = 0; k < len; k++) begin
                if (cw[k]) s = s ^ alog[(j * (len - 1 - k)) % N];
            end
            res[(j-1)*M +: M] = M'(s);
        end
        return res;
    endfunction

    task automatic load_poly(input logic [31:0] poly, input int len);
        cw.delete();
        for (int d = len - 1; d >= 0; d--) cw.push_back(poly[d]);
    endtask

    task automatic make_codeword(input int nerr);
        logic [31:0] c;
        int unsigned msg;
        msg = $urandom_range(0, 127);
        c = '0;
        for (int i = 0; i < 7; i++) begin
            if (msg[i]) c = c ^ (GEN_POLY << i);
        end
        for (int e = 0; e < nerr; e++) c[$urandom_range(0, N - 1)] ^= 1'b1;
        load_poly(c, N);
    endtask

    task automatic send_cw(input int max_gap, input bit with_last);
        int budget;
        int gap;
        for (int k = 0; k < cw.size(); k++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            rx_valid = 1'b0;
            repeat (gap) begin
                rx_bit  = 1'($urandom);
                rx_last = 1'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_bit   = cw[k];
            rx_last  = with_last && (k == cw.size() - 1);
            budget   = 0;
            while (!rx_ready && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
            if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_last  = 1'b0;
        end
    endtask

    task automatic expect_result(input string tag, input int stall);
        logic [SW-1:0] exp_syn;
        exp_syn = ref_syn();
        check({tag, "_valid"},   {31'd0, syn_valid},   32'd1);
        check({tag, "_data"},    32'(syn_data),         32'(exp_syn));
        check({tag, "_error"},   {31'd0, syn_error},   {31'd0, (exp_syn != '0)});
        check({tag, "_len_err"}, {31'd0, syn_len_err}, {31'd0, (cw.size() != N)});
        check({tag, "_rx_busy"}, {31'd0, rx_ready},    32'd0);
        syn_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, {31'd0, syn_valid}, 32'd1);
            check({tag, "_stall_data"},  32'(syn_data),      32'(exp_syn));
        end
        syn_ready = 1'b1;
        @(posedge clk); #1;
        syn_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'd0, syn_valid}, 32'd0);
        check({tag, "_rx_ready"},   {31'd0, rx_ready},  32'd1);
    endtask

    initial begin
        int v;
        int seen;
        v = 1;
        for (int k = 0; k < N; k++) begin
            alog[k] = v;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 'h13;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",  {31'd0, rx_ready},    32'd0);
        check("rst_syn_valid", {31'd0, syn_valid},   32'd0);
        check("rst_syn_error", {31'd0, syn_error},   32'd0);
        check("rst_len_err",   {31'd0, syn_len_err}, 32'd0);
        check("rst_syn_data",  32'(syn_data),        32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // All-zero word
        load_poly(32'd0, N);
        send_cw(0, 1'b1);
        check("zero_lit", 32'(syn_data), 32'h0000);
        expect_result("zero", 1);

        // Single error at x^0
        load_poly(32'd1, N);
        send_cw(0, 1'b1);
        check("x0_lit", 32'(syn_data), 32'h1111);
        expect_result("x0", 0);

        // Single error at x^1
        load_poly(32'd2, N);
        send_cw(0, 1'b1);
        check("x1_lit", 32'(syn_data), 32'h3842);
        expect_result("x1", 2);

        // Generator polynomial itself with input gaps and a stalled output
        load_poly(GEN_POLY, N);
        send_cw(3, 1'b1);
        check("gen_lit", 32'(syn_data), 32'h0000);
        expect_result("gen", 5);

        // Random codewords with 0..3 bit errors
        for (int r = 0; r < 10; r++) begin
            make_codeword($urandom_range(0, 3));
            send_cw($urandom_range(0, 2), 1'b1);
            expect_result("rand", $urandom_range(0, 3));
        end

        // Early rx_last on bit 9
        load_poly(32'($urandom), 10);
        send_cw(1, 1'b1);
        check("short_len_lit", {31'd0, syn_len_err}, 32'd1);
        expect_result("short", 1);

        // Overlong word: 17 bits
        load_poly(32'($urandom), 17);
        send_cw(1, 1'b1);
        check("long_len_lit", {31'd0, syn_len_err}, 32'd1);
        expect_result("long", 1);

        // Reset mid-codeword discards the partial word
        make_codeword(1);
        cw = cw[0:5];
        send_cw(0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_rx_ready",  {31'd0, rx_ready},  32'd0);
        check("midrst_syn_valid", {31'd0, syn_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (syn_valid) seen++;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        make_codeword(2);
        send_cw(0, 1'b1);
        expect_result("after_rst", 1);

        // Reset while a result is pending drops it
        make_codeword(1);
        send_cw(0, 1'b1);
        check("outrst_pre_valid", {31'd0, syn_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("outrst_valid", {31'd0, syn_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (syn_valid) seen++;
        end
        check("outrst_no_valid", 32'(seen), 32'd0);
        make_codeword(0);
        send_cw(2, 1'b1);
        expect_result("after_outrst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
